period_meter: RTL and testbench

//  Parametrised wave-timing counter for the frequency meter datapath.

---
 rtl/freq_meter_pkg.sv | 25 ++
 rtl/wave_sync_edge.sv | 32 +++
 rtl/period_meter.sv | 171 +++++++++++++++++
 tb/tb_period_meter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types for the frequency meter datapath: measurement modes and
// the one-hot state encoding used by the period meter FSM.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        MODE_HIGH   = 2'd0,
        MODE_LOW    = 2'd1,
        MODE_PERIOD = 2'd2,
        MODE_RSVD   = 2'd3
    } meas_mode_t;

    typedef enum logic [4:0] {
        ST_IDLE      = 5'b00001,
        ST_ARM       = 5'b00010,
        ST_WAIT_EDGE = 5'b00100,
        ST_MEASURE   = 5'b01000,
        ST_DONE      = 5'b10000
    } state_t;

    // The reserved encoding behaves as a full-period measurement.
    function automatic meas_mode_t norm_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_PERIOD : meas_mode_t'(m);
    endfunction

endpackage

// File: rtl/wave_sync_edge.sv
// Brings the asynchronous wave into the clk domain and flags its edges.
// rise/fall are combinational against the one-cycle-delayed synced level.
module wave_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wave,
    output logic ws,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_ws_d;

    // Synchroniser chain plus one extra flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_ws_d <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], wave};
            r_ws_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign ws   = r_sync[SYNC_STAGES-1];
    assign rise = ws & ~r_ws_d;
    assign fall = ~ws & r_ws_d;

endmodule

// File: rtl/period_meter.sv
// Wave-timing counter: accumulates high time, low time or full period of
// the synced wave over nper pulses/periods, with saturation and timeout.
//
//  state      | meaning
//  IDLE       | waiting for start; results held
//  ARM        | waiting for the inactive level so a whole pulse is seen
//  WAIT_EDGE  | waiting for the opening edge of the next pulse/period
//  MEASURE    | counting; closing edge ends a pulse (period: each rise)
//  DONE       | one-cycle done pulse, then back to IDLE
module period_meter
    import freq_meter_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NPER_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wave,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [NPER_W-1:0] nper,
    input  logic [WIDTH-1:0]  timeout,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  val,
    output logic              ovf,
    output logic              tmo
);

    localparam logic [WIDTH-1:0] VAL_MAX = '1;

    state_t              r_state;
    meas_mode_t          r_mode;
    logic [NPER_W-1:0]   r_pulses_left;
    logic [WIDTH-1:0]    r_timeout;
    logic [WIDTH-1:0]    r_timer;
    logic [WIDTH-1:0]    r_val;
    logic                r_ovf;
    logic                r_tmo;
    logic                r_done;
    logic                r_busy;

    logic w_ws, w_rise, w_fall;
    logic w_period, w_open_edge, w_term_edge, w_inactive, w_level;
    logic w_last, w_tmo_hit, w_count_en;

    wave_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .wave (wave),
        .ws   (w_ws),
        .rise (w_rise),
        .fall (w_fall)
    );

    assign w_period    = (r_mode == MODE_PERIOD);
    assign w_open_edge = (r_mode == MODE_LOW) ? w_fall : w_rise;
    assign w_term_edge = (r_mode == MODE_HIGH) ? w_fall : w_rise;
    assign w_inactive  = (r_mode == MODE_LOW) ? w_ws : ~w_ws;
    assign w_level     = (r_mode == MODE_LOW) ? ~w_ws : w_ws;
    assign w_last      = (r_pulses_left == NPER_W'(1));
    // Timer holds the number of cycles elapsed before this edge; the edge
    // that would make it equal to timeout is the one that ends the run.
    assign w_tmo_hit   = (r_timeout != '0) && ((r_timer + WIDTH'(1)) == r_timeout);

    // Decide whether the current cycle contributes to the accumulated count.
    always_comb begin
        w_count_en = 1'b0;
        if (!abort) begin
            case (r_state)
                ST_WAIT_EDGE: w_count_en = w_open_edge;
                ST_MEASURE:   w_count_en = w_period ? !(w_rise && w_last) : w_level;
                default:      w_count_en = 1'b0;
            endcase
        end
    end

    // Measurement FSM with saturating accumulator, pulse counter and timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_mode        <= MODE_HIGH;
            r_pulses_left <= '0;
            r_timeout     <= '0;
            r_timer       <= '0;
            r_val         <= '0;
            r_ovf         <= 1'b0;
            r_tmo         <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_count_en) begin
                if (r_val == VAL_MAX) r_ovf <= 1'b1;
                else                  r_val <= r_val + WIDTH'(1);
            end
            if (r_state != ST_IDLE && r_timer != VAL_MAX) r_timer <= r_timer + WIDTH'(1);

            if (abort) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_mode        <= norm_mode(mode);
                            r_pulses_left <= (nper == '0) ? NPER_W'(1) : nper;
                            r_timeout     <= timeout;
                            r_timer       <= '0;
                            r_val         <= '0;
                            r_ovf         <= 1'b0;
                            r_tmo         <= 1'b0;
                            r_busy        <= 1'b1;
                            r_state       <= ST_ARM;
                        end
                    end
                    ST_ARM: begin
                        if (w_tmo_hit) begin
                            r_tmo   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (w_inactive) begin
                            r_state <= ST_WAIT_EDGE;
                        end
                    end
                    ST_WAIT_EDGE: begin
                        if (w_tmo_hit) begin
                            r_tmo   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (w_open_edge) begin
                            r_state <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE: begin
                        if (w_term_edge && w_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (w_tmo_hit) begin
                            r_tmo   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (w_term_edge) begin
                            r_pulses_left <= r_pulses_left - NPER_W'(1);
                            if (!w_period) r_state <= ST_WAIT_EDGE;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign val  = r_val;
    assign ovf  = r_ovf;
    assign tmo  = r_tmo;

endmodule

// File: tb/tb_period_meter.sv
// Directed + randomized bench for period_meter. Wave is 5 clk high / 3 clk
// low; expected results come from that shape and the measurement rules.
module tb_period_meter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wave;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [7:0]  nper;
    logic [31:0] timeout;
    logic [3:0]  timeout4;
    logic        busy, done, ovf, tmo;
    logic [31:0] val;
    logic        busy4, done4, ovf4, tmo4;
    logic [3:0]  val4;

    int  checks = 0;
    int  errors = 0;
    int  done_cnt = 0;
    bit  wave_run = 1'b0;

    period_meter u_dut (
        .clk(clk), .rst_n(rst_n), .wave(wave), .start(start), .abort(abort),
        .mode(mode), .nper(nper), .timeout(timeout),
        .busy(busy), .done(done), .val(val), .ovf(ovf), .tmo(tmo)
    );

    period_meter #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .wave(wave), .start(start), .abort(abort),
        .mode(mode), .nper(nper), .timeout(timeout4),
        .busy(busy4), .done(done4), .val(val4), .ovf(ovf4), .tmo(tmo4)
    );

    always #5 clk = ~clk;

    initial begin
        wave = 1'b0;
        forever begin
            if (wave_run) begin
                wave = 1'b1;
                repeat (5) @(negedge clk);
                wave = 1'b0;
                repeat (3) @(negedge clk);
            end else begin
                wave = 1'b0;
                @(negedge clk);
            end
        end
    end

    always @(posedge clk) if (rst_n === 1'b1 && done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint exp_val(input int m, input int n);
        int k;
        k = (n == 0) ? 1 : n;
        case (m)
            0:       return 5 * k;
            1:       return 3 * k;
            default: return 8 * k;
        endcase
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit ok);
        cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic abort_pulse();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic measure(input int m, input int n, input string tag, input bit chk4);
        int     cyc;
        bit     ok;
        int     base;
        longint e;
        e = exp_val(m, n);
        repeat ($urandom_range(0, 7)) @(negedge clk);
        base    = done_cnt;
        mode    = 2'(m);
        nper    = 8'(n);
        timeout = 32'd0;
        do_start();
        wait_done(400, cyc, ok);
        check({tag, "_done_seen"}, 64'(ok), 64'd1);
        if (!ok) begin
            abort_pulse();
        end else begin
            check({tag, "_val"}, 64'(val), 64'(e));
            check({tag, "_ovf"}, 64'(ovf), 64'd0);
            check({tag, "_tmo"}, 64'(tmo), 64'd0);
            if (chk4) begin
                check({tag, "_w4_done"}, 64'(done4), 64'd1);
                check({tag, "_w4_val"}, 64'(val4), (e > 15) ? 64'd15 : 64'(e));
                check({tag, "_w4_ovf"}, 64'(ovf4), (e > 15) ? 64'd1 : 64'd0);
            end
            @(negedge clk);
            check({tag, "_done_width"}, 64'(done), 64'd0);
            repeat (20) @(negedge clk);
            check({tag, "_done_count"}, 64'(done_cnt - base), 64'd1);
            check({tag, "_idle"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        int  cyc;
        bit  ok;
        int  base;
        int  m;
        int  n;

        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        mode     = 2'd0;
        nper     = 8'd1;
        timeout  = 32'd0;
        timeout4 = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_val", 64'(val), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_tmo", 64'(tmo), 64'd0);
        rst_n    = 1'b1;
        wave_run = 1'b1;
        repeat (10) @(negedge clk);

        measure(0, 1, "high_n1", 1'b1);
        measure(0, 4, "high_n4", 1'b1);
        measure(1, 0, "low_n0", 1'b1);

        // PERIOD x2 with a second start (different settings) while busy.
        repeat ($urandom_range(0, 7)) @(negedge clk);
        base    = done_cnt;
        mode    = 2'd2;
        nper    = 8'd2;
        do_start();
        repeat (6) @(negedge clk);
        check("per_busy", 64'(busy), 64'd1);
        mode = 2'd0;
        nper = 8'd1;
        do_start();
        wait_done(400, cyc, ok);
        check("per_done_seen", 64'(ok), 64'd1);
        check("per_val", 64'(val), 64'd16);
        repeat (30) @(negedge clk);
        check("per_done_count", 64'(done_cnt - base), 64'd1);

        for (int i = 0; i < 8; i++) begin
            m = $urandom_range(0, 3);
            n = $urandom_range(0, 5);
            measure(m, n, $sformatf("rnd%0d_m%0d_n%0d", i, m, n), 1'b1);
        end

        // Timeout with the wave parked low.
        wave_run = 1'b0;
        repeat (15) @(negedge clk);
        mode    = 2'd0;
        nper    = 8'd1;
        timeout = 32'd50;
        do_start();
        wait_done(200, cyc, ok);
        check("tmo_done_seen", 64'(ok), 64'd1);
        check("tmo_latency", 64'(cyc), 64'd50);
        check("tmo_flag", 64'(tmo), 64'd1);
        check("tmo_val", 64'(val), 64'd0);
        check("tmo_ovf", 64'(ovf), 64'd0);
        timeout = 32'd0;
        repeat (3) @(negedge clk);

        // Abort part-way through a long HIGH x4 measurement.
        wave_run = 1'b1;
        mode     = 2'd0;
        nper     = 8'd4;
        abort_pulse();
        repeat ($urandom_range(0, 7)) @(negedge clk);
        base = done_cnt;
        do_start();
        repeat (25) @(negedge clk);
        check("abt_busy_before", 64'(busy), 64'd1);
        abort_pulse();
        check("abt_busy_after", 64'(busy), 64'd0);
        check("abt_val_partial", 64'((val > 0) && (val < 20)), 64'd1);
        repeat (40) @(negedge clk);
        check("abt_no_done", 64'(done_cnt - base), 64'd0);
        check("abt_stays_idle", 64'(busy), 64'd0);

        // Asynchronous reset mid-measurement, then a clean measurement.
        base = done_cnt;
        do_start();
        repeat (25) @(negedge clk);
        check("rmid_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rmid_busy", 64'(busy), 64'd0);
        check("rmid_done", 64'(done), 64'd0);
        check("rmid_val", 64'(val), 64'd0);
        check("rmid_ovf", 64'(ovf), 64'd0);
        check("rmid_tmo", 64'(tmo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        measure(0, 1, "post_rst", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
